// File: rtl/a0_logger_pkg.sv
// Shared types and constants for the a0 change-capture logger.
// Default-width record layout, overflow counter width, saturating increment.
// No logic state lives here.
package a0_logger_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SEQ_W_DEF      = 8;
  localparam int OVF_W          = 16;

  // Record as seen by the consumer at default widths: sequence above data.
  typedef struct packed {
    logic [SEQ_W_DEF-1:0]      seq;
    logic [DATA_WIDTH_DEF-1:0] data;
  } log_entry_t;

  // Saturating increment for the dropped-event counter.
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/a0_logger_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is always visible on rd_dat.
// Latency: a push becomes visible on rd_dat/empty the cycle after the edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     rd_dat,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full   = (level_q == FULL_LVL);
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rd_dat = mem_q[rd_ptr_q];

  // Next-state: flush wins; otherwise accept push/pop, pop frees a slot for a full push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      do_pop   = 1'b0;
      do_push  = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage and pointers; storage is cleared on reset so the idle head reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/a0_logger.sv
// Logs each distinct a0 value with a sequence number into a show-ahead FIFO.
// Latency: one cycle from a0 change to out_valid; no combinational path from a0_in.
// Backpressure: out_ready=0 fills the FIFO; events while full are dropped and counted.
module a0_logger
  import a0_logger_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clear,
  input  logic [DATA_WIDTH-1:0]      a0_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic [OVF_W-1:0]           overflow_cnt
);

  typedef struct packed {
    logic [SEQ_W-1:0]      seq;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [DATA_WIDTH-1:0] last_val_q, last_val_d;
  logic                  have_last_q, have_last_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [OVF_W-1:0]      ovf_q, ovf_d;

  logic   evt;
  logic   pop;
  logic   push;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t push_ent;
  entry_t head_ent;

  assign out_valid    = !fifo_empty;
  assign out_data     = head_ent.data;
  assign out_seq      = head_ent.seq;
  assign overflow_cnt = ovf_q;
  assign pop          = out_valid && out_ready;
  assign push_ent     = '{seq: seq_q, data: a0_in};

  // Change detection, push/drop decision and bookkeeping; clear overrides everything.
  always_comb begin
    last_val_d  = last_val_q;
    have_last_d = have_last_q;
    seq_d       = seq_q;
    ovf_d       = ovf_q;
    evt         = en && (!have_last_q || (a0_in != last_val_q));
    push        = 1'b0;
    if (clear) begin
      have_last_d = 1'b0;
      seq_d       = '0;
      ovf_d       = '0;
    end else if (evt) begin
      last_val_d  = a0_in;
      have_last_d = 1'b1;
      seq_d       = seq_q + SEQ_W'(1);
      if (!fifo_full || pop) begin
        push = 1'b1;
      end else begin
        ovf_d = sat_inc(ovf_q);
      end
    end
  end

  // Detector and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val_q  <= '0;
      have_last_q <= 1'b0;
      seq_q       <= '0;
      ovf_q       <= '0;
    end else begin
      last_val_q  <= last_val_d;
      have_last_q <= have_last_d;
      seq_q       <= seq_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop && !clear),
    .flush    (clear),
    .rd_dat   (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

endmodule

// File: tb/tb_a0_logger.sv
// Directed bench for a0_logger with a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Literal expectations pin the model at the test-plan checkpoints.
module tb_a0_logger;
  import a0_logger_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] a0_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_seq;
  logic [3:0]    level;
  logic [15:0]   overflow_cnt;

  a0_logger #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SEQ_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clear        (clear),
    .a0_in        (a0_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_seq      (out_seq),
    .level        (level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: list of pending records plus detector state.
  log_entry_t  mq[$];
  logic [31:0] m_last;
  bit          m_have;
  logic [7:0]  m_seq;
  int          m_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_have = 0;
    m_seq  = 0;
    m_ovf  = 0;
    m_last = 0;
  endtask

  // Advance the model by one clock using the inputs about to be applied.
  task automatic model_step(input bit e, input bit c, input logic [31:0] v, input bit r);
    bit was_full, p, ev;
    log_entry_t rec;
    if (c) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    p  = (mq.size() > 0) && r;
    ev = e && (!m_have || v != m_last);
    if (p) void'(mq.pop_front());
    if (ev) begin
      rec.seq  = m_seq;
      rec.data = v;
      if (!was_full || p) mq.push_back(rec);
      else if (m_ovf < 16'hFFFF) m_ovf++;
      m_last = v;
      m_have = 1;
      m_seq  = m_seq + 8'd1;
    end
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, mq.size() > 0);
    check("level", level, mq.size());
    check("overflow_cnt", overflow_cnt, m_ovf);
    if (out_valid && mq.size() > 0) begin
      check("out_data", out_data, mq[0].data);
      check("out_seq", out_seq, mq[0].seq);
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare against the model.
  task automatic step(input bit e, input bit c, input logic [31:0] v, input bit r);
    en = e; clear = c; a0_in = v; out_ready = r;
    model_step(e, c, v, r);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_seq", out_seq, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic capture: 5,5,7,7,7,9
    step(1, 0, 5, 1);
    check("cap5_data", out_data, 5); check("cap5_seq", out_seq, 0);
    step(1, 0, 5, 1);
    check("cap5_rep_valid", out_valid, 0);
    step(1, 0, 7, 1);
    check("cap7_data", out_data, 7); check("cap7_seq", out_seq, 1);
    step(1, 0, 7, 1);
    step(1, 0, 7, 1);
    check("cap7_rep_valid", out_valid, 0);
    step(1, 0, 9, 1);
    check("cap9_data", out_data, 9); check("cap9_seq", out_seq, 2);
    step(0, 0, 9, 1);

    // Backpressure and overflow: 10 distinct values with no consumer
    step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 100 + i, 0);
    check("bp_level", level, 8);
    check("bp_ovf", overflow_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      check("drain_seq", out_seq, i);
      check("drain_data", out_data, 100 + i);
      step(0, 0, 0, 1);
    end
    check("drain_empty", out_valid, 0);

    // Full FIFO with simultaneous pop and event
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 200 + i, 0);
    check("full_level", level, 8);
    step(1, 0, 300, 1);
    check("fullpop_level", level, 8);
    check("fullpop_ovf", overflow_cnt, 0);
    check("fullpop_head", out_seq, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);

    // Enable gating: last value held across en=0
    step(0, 1, 0, 1);
    step(1, 0, 50, 1);
    step(1, 0, 50, 1);
    step(0, 0, 1, 1);
    step(0, 0, 2, 1);
    step(0, 0, 3, 1);
    check("gate_novalid", out_valid, 0);
    step(1, 0, 3, 1);
    check("gate_data", out_data, 3); check("gate_seq", out_seq, 1);
    step(1, 0, 3, 1);
    check("gate_once", level, 0);

    // Clear with 4 entries and 3 drops, alongside an event
    step(0, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 400 + i, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    check("pre_clr_level", level, 4);
    check("pre_clr_ovf", overflow_cnt, 3);
    step(1, 1, 999, 0);
    check("clr_level", level, 0);
    check("clr_ovf", overflow_cnt, 0);
    check("clr_valid", out_valid, 0);
    step(1, 0, 999, 0);
    check("post_clr_seq", out_seq, 0);
    check("post_clr_data", out_data, 999);

    // Async reset mid-drain, between clock edges
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 500 + i, 0);
    step(0, 0, 0, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", level, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 32'h2A, 0);
    check("arst_after_data", out_data, 32'h2A);
    check("arst_after_seq", out_seq, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/a0_logger.md
# a0_logger

Change-capture logger downstream of the single-cycle CPU top. Samples the CPU's `a0` result register every clock and records each distinct value with a sequence number. Buffers the records in a small show-ahead FIFO and streams them to the display or host side over a valid/ready handshake. Counts changes lost to a full buffer so the consumer can detect gaps.

## Interface
- `DATA_WIDTH`, default 32: width of `a0_in` and `out_data`.
- `DEPTH`, default 8: number of FIFO entries; must be a power of 2 and at least 2.
- `SEQ_W`, default 8: sequence-number width.
- `clk` in, 1: single clock; every register updates on the rising edge.
- `rst` in, 1: reset, asynchronous and active-low.
- `en` in, 1: capture enable; when 0, `a0_in` is ignored.
- `clear` in, 1: synchronous flush.
- `a0_in` in, DATA_WIDTH: the CPU's `a0` output.
- `out_valid` out, 1: FIFO head holds a record.
- `out_ready` in, 1: consumer accepts the head record.
- `out_data` out, DATA_WIDTH: head record value.
- `out_seq` out, SEQ_W: head record sequence number.
- `level` out, $clog2(DEPTH)+1: current number of FIFO entries.
- `overflow_cnt` out, 16: dropped-event count; saturates at 16'hFFFF.

## Operation
- **Change event:** occurs in a cycle where `en`=1 and either `have_last`=0 or `a0_in` != `last_val`.
  - On an event: `last_val` <= `a0_in`, `have_last` <= 1, `seq` <= `seq`+1 (wraps modulo 2^SEQ_W).
  - The record {`seq` before increment, `a0_in`} is the push candidate.
- **Pop:** `out_valid` && `out_ready`. The head advances.
- **Push:** an event while `level` < DEPTH, or while `level` == DEPTH and a pop occurs in the same cycle.
  - Full plus simultaneous pop: push and pop both happen and `level` stays DEPTH.
- **Drop:** an event while full with no pop.
  - The record is discarded, `overflow_cnt` increments (saturating), and `seq` still increments, so the consumer sees a sequence gap.
  - `last_val` still updates.
- **Empty plus event:** push only; there is no bypass, so the record appears the next cycle.
- **`en`=0:** no events. `last_val` and `have_last` hold their values. Pops continue normally.
- **`clear`=1:** has priority over push, pop and event in the same cycle.
  - Empties the FIFO (`level`=0).
  - Zeroes `have_last`, `seq` and `overflow_cnt`.
  - The first enabled cycle after `clear` is always an event.
- **Reset:**
  - `out_valid`=0, `out_data`=0, `out_seq`=0, `level`=0, `overflow_cnt`=0.
  - Internally `have_last`=0, `seq`=0, and FIFO pointers are 0.
  - Reset asserted mid-stream discards all records immediately, regardless of `out_ready`.
- **Output data when empty:** `out_data`/`out_seq` are don't-care; implementation drives the stale head entry. The bench must only check them while `out_valid`=1.
- **Output stability:** `out_data`/`out_seq` remain stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency: `a0_in` changes before edge N (`en`=1) → record pushed at edge N → `out_valid`=1 and `out_data`=value after edge N (one cycle).
- `out_valid`, `out_data`, `out_seq`, `level` and `overflow_cnt` are all registered or driven directly from FIFO storage and pointers. There is no combinational path from `a0_in`.
- `out_ready` may combinationally affect only push acceptance when full. It never affects `out_valid` in the same cycle.
- Throughput: one push and one pop per cycle sustained.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is tracked as a separate counter, or as pointer difference with an extra MSB.

## Structure
- Package `a0_logger_pkg`:
  - `typedef struct packed {logic [SEQ_W-1:0] seq; logic [DATA_WIDTH-1:0] data;} log_entry_t`, with package-level default widths.
  - Constant `OVF_W`=16.
- Sub-module `sync_fifo`, parameterised on entry type width and DEPTH:
  - Show-ahead behaviour.
  - `push`/`pop`/`flush` inputs; `full`/`empty`/`level` outputs.
  - Async active-low reset.
- The top level holds the change detector, the `seq` counter, the overflow counter and the push-while-full-with-pop decision.

## Test plan
- **Basic capture:** reset, `en`=1, `out_ready`=1, `a0_in` = 5,5,7,7,7,9 on consecutive cycles → records (seq 0, 5), (1, 7), (2, 9), each one cycle after its first appearance; no record for repeats.
- **Backpressure and overflow:** `out_ready`=0, DEPTH=8, 10 distinct values → `level`=8, `overflow_cnt`=2. Then raise `out_ready` → drain seq 0..7 in order, values intact.
- **Full plus simultaneous pop and event:** full FIFO, `out_ready`=1, new value in the same cycle → pushed, `level` stays 8, `overflow_cnt` unchanged.
- **Enable gating:** `en`=0 while `a0_in` toggles 1→2→3, then `en`=1 with `a0_in`=3 → exactly one record (3), since `last_val` was held from before.
- **Clear:** 4 entries, `overflow_cnt`=3, pulse `clear` alongside an event → `level`=0, `overflow_cnt`=0, `out_valid`=0, next enabled cycle logs seq 0.
- **Async reset:** assert `rst` low mid-drain between clock edges → `out_valid` drops immediately. Release, then `a0_in`=0x2A → record (seq 0, 0x2A).
